// File: rtl/prescaled_counter_pkg.sv
// Shared constants for the prescaled counter: count directions and default widths.
package prescaled_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int WIDTH_DEF = 12;
    localparam int DIV_W_DEF = 23;

endpackage

// File: rtl/prescaled_counter_tick_gen.sv
// Prescaler for the prescaled counter: emits a one-cycle tick every div_max+1 enabled cycles.
module tick_gen
    import prescaled_counter_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_div_max,
    output logic             o_tick
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_presc;
    logic             w_match;

    // Exact match only: a lowered div_max lets the prescaler run through 2^DIV_W before stepping.
    assign w_match = (r_presc == i_div_max);
    assign o_tick  = i_en && !i_clr && w_match;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
        end else if (i_clr) begin
            r_presc <= '0;
        end else if (i_en) begin
            if (w_match) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + ONE;
            end
        end
    end

endmodule

// File: rtl/prescaled_counter.sv
// Prescaled up/down counter with programmable modulo, load, enable and step/wrap strobes.
// Define PRESCALED_COUNTER_SATURATE_EN to saturate at the range ends instead of wrapping.
module prescaled_counter
    import prescaled_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_up,
    input  logic [DIV_W-1:0] i_div_max,
    input  logic [WIDTH-1:0] i_max_val,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_step,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_step;
    logic             r_wrap;
    logic             w_tick;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_wrap;

    tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (i_en),
        .i_clr     (i_load),
        .i_div_max (i_div_max),
        .o_tick    (w_tick)
    );

    // Value and wrap flag the count would take if a step happened this cycle.
    always_comb begin
        w_next_count = r_count;
        w_next_wrap  = 1'b0;
        if (i_up == DIR_UP) begin
            if (r_count >= i_max_val) begin
`ifdef PRESCALED_COUNTER_SATURATE_EN
                w_next_count = i_max_val;
`else
                w_next_count = '0;
                w_next_wrap  = 1'b1;
`endif
            end else begin
                w_next_count = r_count + ONE;
`ifdef PRESCALED_COUNTER_SATURATE_EN
                w_next_wrap  = (w_next_count == i_max_val);
`endif
            end
        end else begin
            if (r_count == '0) begin
`ifdef PRESCALED_COUNTER_SATURATE_EN
                w_next_count = '0;
`else
                w_next_count = i_max_val;
                w_next_wrap  = 1'b1;
`endif
            end else if (r_count > i_max_val) begin
                w_next_count = i_max_val;
            end else begin
                w_next_count = r_count - ONE;
`ifdef PRESCALED_COUNTER_SATURATE_EN
                w_next_wrap  = (r_count == ONE);
`endif
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (i_load) begin
            r_count <= i_load_val;
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (w_tick) begin
            r_count <= w_next_count;
            r_step  <= 1'b1;
            r_wrap  <= w_next_wrap;
        end else begin
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
        end
    end

    assign o_count = r_count;
    assign o_step  = r_step;
    assign o_wrap  = r_wrap;

endmodule

// File: tb/tb_prescaled_counter.sv
// Directed self-checking bench for prescaled_counter (honours PRESCALED_COUNTER_SATURATE_EN).
module tb_prescaled_counter;

    localparam int WIDTH = 12;
    localparam int DIV_W = 23;

    logic             clk = 1'b0;
    logic             rstN;
    logic             en;
    logic             up;
    logic [DIV_W-1:0] divMax;
    logic [WIDTH-1:0] maxVal;
    logic             load;
    logic [WIDTH-1:0] loadVal;
    logic [WIDTH-1:0] count;
    logic             step;
    logic             wrap;

    int assertCount = 0;
    int failCount   = 0;
    int stepSeen    = 0;
    int expCount[5];
    int expWrap[5];

    prescaled_counter #(
        .WIDTH (WIDTH),
        .DIV_W (DIV_W)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_en       (en),
        .i_up       (up),
        .i_div_max  (divMax),
        .i_max_val  (maxVal),
        .i_load     (load),
        .i_load_val (loadVal),
        .o_count    (count),
        .o_step     (step),
        .o_wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input int expC, input logic expS, input logic expW);
        compare({tag, "_count"}, 32'(count), 32'(expC));
        compare({tag, "_step"}, 32'(step), 32'(expS));
        compare({tag, "_wrap"}, 32'(wrap), 32'(expW));
    endtask

    // Drive one cycle's inputs, then advance to just after the next rising edge.
    task automatic applyStimulus(input logic e, input logic u, input int dm, input int mv,
                                 input logic ld, input int lv);
        en      = e;
        up      = u;
        divMax  = dm[DIV_W-1:0];
        maxVal  = mv[WIDTH-1:0];
        load    = ld;
        loadVal = lv[WIDTH-1:0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN    = 1'b0;
        en      = 1'b0;
        up      = 1'b1;
        divMax  = 3;
        maxVal  = 5;
        load    = 1'b0;
        loadVal = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset", 0, 1'b0, 1'b0);

        $display("[TB] up count, div_max=3 max_val=5");
        rstN = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            applyStimulus(1'b1, 1'b1, 3, 5, 1'b0, 0);
            checkOutput($sformatf("upRun%0d", i), (i / 4) % 6, (i % 4) == 0, i == 24);
            if (step === 1'b1) stepSeen++;
        end
        compare("stepCount", 32'(stepSeen), 32'd6);

        $display("[TB] mid-period load");
        applyStimulus(1'b1, 1'b1, 3, 5, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 3, 5, 1'b0, 0);
        checkOutput("preLoad", 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 3, 5, 1'b1, 7);
        checkOutput("load", 7, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 1'b1, 3, 5, 1'b0, 0);
            checkOutput($sformatf("postLoad%0d", i), 7, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 3, 5, 1'b0, 0);
        checkOutput("loadWrap", 0, 1'b1, 1'b1);

        $display("[TB] enable pause");
        applyStimulus(1'b1, 1'b1, 3, 5, 1'b0, 0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 1'b1, 3, 5, 1'b0, 0);
            checkOutput($sformatf("paused%0d", i), 0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 3, 5, 1'b0, 0);
        checkOutput("resume1", 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 3, 5, 1'b0, 0);
        checkOutput("resume2", 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 3, 5, 1'b0, 0);
        checkOutput("resume3", 1, 1'b1, 1'b0);

        $display("[TB] down count, div_max=0 max_val=9");
        applyStimulus(1'b1, 1'b0, 0, 9, 1'b1, 0);
        checkOutput("downLoad0", 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 9, 1'b0, 0);
        checkOutput("downWrap", 9, 1'b1, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 1'b0, 0, 9, 1'b0, 0);
            checkOutput($sformatf("down%0d", i), 9 - i, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 0, 9, 1'b1, 12);
        checkOutput("loadAbove", 12, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 9, 1'b0, 0);
        checkOutput("downClamp", 9, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 0, 9, 1'b0, 0);
        checkOutput("upAtMax", 0, 1'b1, 1'b1);

        $display("[TB] asynchronous reset mid-count");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b1, 0, 9, 1'b0, 0);
        end
        checkOutput("preReset", 4, 1'b1, 1'b0);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("asyncReset", 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 0, 9, 1'b0, 0);
        checkOutput("heldReset", 0, 1'b0, 1'b0);
        rstN = 1'b1;
        applyStimulus(1'b1, 1'b1, 0, 9, 1'b0, 0);
        checkOutput("postReset", 1, 1'b1, 1'b0);

        $display("[TB] max_val=0");
        for (int i = 1; i <= 2; i++) begin
            applyStimulus(1'b1, 1'b1, 0, 0, 1'b0, 0);
            checkOutput($sformatf("maxZero%0d", i), 0, 1'b1, 1'b1);
        end

`ifdef PRESCALED_COUNTER_SATURATE_EN
        $display("[TB] saturating up count, max_val=3");
        expCount = '{1, 2, 3, 3, 3};
        expWrap  = '{0, 0, 1, 0, 0};
`else
        $display("[TB] wrapping up count, max_val=3");
        expCount = '{1, 2, 3, 0, 1};
        expWrap  = '{0, 0, 0, 1, 0};
`endif
        applyStimulus(1'b1, 1'b1, 0, 3, 1'b1, 0);
        checkOutput("max3Load", 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 0, 3, 1'b0, 0);
            checkOutput($sformatf("max3Step%0d", i), expCount[i], 1'b1, expWrap[i] != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/prescaled_counter.md
Name: prescaled_counter

Overview:
- Parametrised successor to the free-running prescaled up-counter.
- Adds the following to the fixed-width count/divider:
  - runtime divide ratio
  - up/down direction
  - programmable modulo (terminal value)
  - synchronous load
  - enable
  - step and wrap strobes
- Drives display/LED counters and timebases in the lab designs.
- Other blocks can cascade from its wrap strobe.

Parameters:
- WIDTH, 12, width of count, max_val and load_val.
- DIV_W, 23, width of the prescaler register and div_max.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advance prescaler and counter when 1; hold when 0.
- up  input  1  direction: 1 = count up, 0 = count down; sampled on the step cycle.
- div_max  input  DIV_W  prescaler terminal value; step every div_max+1 enabled cycles.
- max_val  input  WIDTH  counter terminal value; count range 0..max_val.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value loaded on load.
- count  output  WIDTH  current count, registered.
- step  output  1  registered one-cycle pulse: count advanced this edge.
- wrap  output  1  registered one-cycle pulse: count wrapped this edge.

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, prescaler=0, step=0, wrap=0. Release is effective at the next clk edge.
- Prescaler:
  - When en=1, prescaler increments each cycle.
  - When prescaler==div_max and en=1, a step occurs and the prescaler returns to 0.
  - div_max=0 gives a step on every enabled cycle.
  - If div_max is lowered below the current prescaler value, the prescaler counts on, wraps at 2^DIV_W, then matches. No early step.
- First step: with en held high from reset release, the first count change happens on the (div_max+1)th enabled edge.
- Up step:
  - count>=max_val: count<=0, wrap=1.
  - Otherwise: count<=count+1.
- Down step:
  - count==0: count<=max_val, wrap=1.
  - count>max_val: count<=max_val, wrap=0.
  - Otherwise: count<=count-1.
- max_val=0: count stays at 0, and wrap pulses on every step.
- step: asserted for exactly the cycle after the edge that advanced count, aligned with the new count value.
- wrap: asserted only together with step.
- load:
  - Has highest priority after reset.
  - count<=load_val, prescaler<=0, step=0, wrap=0.
  - Takes effect regardless of en.
  - load_val>max_val is loaded unchanged. The next up step wraps it to 0; the next down step clamps it to max_val.
- en=0 without load: prescaler and count hold; step and wrap are 0.
- Arithmetic: all arithmetic is modulo its register width; there are no overflow side-effects.

Optional Feature:
- Macro: PRESCALED_COUNTER_SATURATE_EN.
- Defined:
  - Up: count sticks at max_val. wrap pulses once, on the step that first reaches max_val. Further steps still pulse step and leave count unchanged.
  - Down: count sticks at 0, with the same wrap rule.
  - load releases saturation.
- Undefined: wrap-around behaviour as described above.

Decomposition:
- Package prescaled_counter_pkg holds:
  - direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0
  - default widths WIDTH_DEF=12 and DIV_W_DEF=23
- Sub-module tick_gen holds:
  - the prescaler register
  - ports clk, rst_n, en, clr (driven by load), div_max
  - a single-cycle tick output
- Top level holds the count/wrap logic.

Test Plan:
- Reset, then en=1, up=1, div_max=3, max_val=5 -> count 1 on the 4th edge, then advances every 4 cycles: 1,2,3,4,5,0. wrap pulses once with count=0. step pulses 6 times in 24 cycles.
- div_max=0, up=0, max_val=9, from count=0 -> count 9 (wrap=1), then 8, 7, ... one per cycle.
- Mid-period load: load=1, load_val=7 with prescaler at 2 of div_max=3 -> count=7, no step or wrap. Next step occurs exactly 4 enabled cycles later.
- en toggled low for 10 cycles mid-period -> count and prescaler frozen; step resumes after the remaining cycles of the period.
- Assert rst_n=0 asynchronously mid-count (count=4) -> count=0 before the next clk edge; step=0, wrap=0.
- Run with PRESCALED_COUNTER_SATURATE_EN, max_val=3, up=1, div_max=0 -> count 1,2,3,3,3. wrap is high only on the edge reaching 3; step is high on every cycle.
